// File: rtl/cb_seg_pkg.sv
// Shared constants and types for the code-block segmentation sequencer.
// Block sizes, slot encodings, FSM states and the descriptor layout live here.
package cb_seg_pkg;

    localparam int K_BIG   = 6144;
    localparam int K_SMALL = 1056;
    localparam int CRC_LEN = 24;
    localparam int CNT_W   = 13;

    typedef enum logic [1:0] {
        SLOT_DATA = 2'b00,
        SLOT_FILL = 2'b01,
        SLOT_CRC  = 2'b10
    } slot_type_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FILL = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4
    } seg_state_t;

    typedef struct packed {
        logic [1:0]  c_plus;
        logic [1:0]  c_minus;
        logic [15:0] filler;
    } desc_t;

    function automatic logic [CNT_W-1:0] blk_size(input logic k_big);
        return k_big ? CNT_W'(K_BIG) : CNT_W'(K_SMALL);
    endfunction

endpackage

// File: rtl/cb_seg_out_reg.sv
// Single-entry ready/valid output register for the segmented bit stream.
// Payload is only reloaded when the stage advances, so it stays stable under stall.
module cb_seg_out_reg
    import cb_seg_pkg::*;
(
    input  logic       clk,
    input  logic       aclr_n,
    input  logic       i_push,
    input  logic       i_bit,
    input  slot_type_t i_type,
    input  logic       i_sob,
    input  logic       i_eob,
    input  logic       i_blk_idx,
    input  logic       i_k_big,
    input  logic       i_last,
    input  logic       i_ready,
    output logic       o_can_adv,
    output logic       o_valid,
    output logic       o_bit,
    output slot_type_t o_type,
    output logic       o_sob,
    output logic       o_eob,
    output logic       o_blk_idx,
    output logic       o_k_big,
    output logic       o_last
);

    logic       r_valid;
    logic       r_bit;
    slot_type_t r_type;
    logic       r_sob;
    logic       r_eob;
    logic       r_blk_idx;
    logic       r_k_big;
    logic       r_last;
    logic       w_adv;

    assign w_adv = !r_valid || i_ready;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_valid   <= 1'b0;
            r_bit     <= 1'b0;
            r_type    <= SLOT_DATA;
            r_sob     <= 1'b0;
            r_eob     <= 1'b0;
            r_blk_idx <= 1'b0;
            r_k_big   <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_adv) begin
            r_valid <= i_push;
            if (i_push) begin
                r_bit     <= i_bit;
                r_type    <= i_type;
                r_sob     <= i_sob;
                r_eob     <= i_eob;
                r_blk_idx <= i_blk_idx;
                r_k_big   <= i_k_big;
                r_last    <= i_last;
            end
        end
    end

    assign o_can_adv = w_adv;
    assign o_valid   = r_valid;
    assign o_bit     = r_bit;
    assign o_type    = r_type;
    assign o_sob     = r_sob;
    assign o_eob     = r_eob;
    assign o_blk_idx = r_blk_idx;
    assign o_k_big   = r_k_big;
    assign o_last    = r_last;

endmodule

// File: rtl/cb_seg_sequencer.sv
// Splits a transport block into one or two code blocks: filler, data, then a
// CRC slot per block when the TB is split in two.
module cb_seg_sequencer
    import cb_seg_pkg::*;
(
    input  logic        clk,
    input  logic        aclr_n,
    input  logic        desc_empty,
    output logic        desc_rd,
    input  logic [19:0] desc_q,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_bit,
    output logic [1:0]  out_type,
    output logic        out_sob,
    output logic        out_eob,
    output logic        out_blk_idx,
    output logic        out_k_big,
    output logic        tb_done,
    output logic        desc_err
);

    seg_state_t       r_state;
    logic             r_armed;
    logic             r_crc_on;
    logic             r_k_big;
    logic             r_blk1_big;
    logic             r_blk_idx;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_filler;

    desc_t            w_desc;
    logic [2:0]       w_c;
    logic             w_crc_on_ld;
    logic [CNT_W-1:0] w_cap0;
    logic             w_reject;
    logic [CNT_W-1:0] w_k;
    logic             w_eob;
    logic             w_data_last;
    logic             w_last_blk;
    logic             w_can_adv;
    logic             w_push;
    slot_type_t       w_type;
    slot_type_t       w_out_type;
    logic             w_out_last;

    assign w_desc      = desc_q;
    assign w_c         = {1'b0, w_desc.c_plus} + {1'b0, w_desc.c_minus};
    assign w_crc_on_ld = (w_c == 3'd2);
    // Block 0 is the small size whenever any C_minus block exists.
    assign w_cap0      = blk_size(w_desc.c_minus == 2'd0)
                         - (w_crc_on_ld ? CNT_W'(CRC_LEN) : '0);
    assign w_reject    = (w_c == 3'd0) || (w_c > 3'd2)
                         || (w_desc.filler >= {3'b000, w_cap0});

    assign w_k         = blk_size(r_k_big);
    assign w_eob       = (r_bit_cnt == w_k - 1'b1);
    assign w_data_last = (r_bit_cnt == w_k - CNT_W'(CRC_LEN) - 1'b1);
    assign w_last_blk  = !r_crc_on || r_blk_idx;

    assign w_push = w_can_adv && ((r_state == ST_FILL) || (r_state == ST_CRC)
                                  || ((r_state == ST_DATA) && in_valid));

    always_comb begin
        w_type = SLOT_DATA;
        case (r_state)
            ST_FILL: w_type = SLOT_FILL;
            ST_CRC:  w_type = SLOT_CRC;
            default: w_type = SLOT_DATA;
        endcase
    end

    // r_armed keeps desc_rd low while reset is asserted.
    assign desc_rd  = (r_state == ST_IDLE) && r_armed && !desc_empty && !out_valid;
    assign desc_err = (r_state == ST_LOAD) && w_reject;
    assign in_ready = (r_state == ST_DATA) && w_can_adv;
    assign tb_done  = out_valid && out_ready && w_out_last;
    assign out_type = w_out_type;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_crc_on   <= 1'b0;
            r_k_big    <= 1'b0;
            r_blk1_big <= 1'b0;
            r_blk_idx  <= 1'b0;
            r_bit_cnt  <= '0;
            r_filler   <= '0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (desc_rd) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_reject) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_filler   <= w_desc.filler[CNT_W-1:0];
                        r_crc_on   <= w_crc_on_ld;
                        r_k_big    <= (w_desc.c_minus == 2'd0);
                        r_blk1_big <= (w_desc.c_minus != 2'd2);
                        r_blk_idx  <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= (w_desc.filler != 16'd0) ? ST_FILL : ST_DATA;
                    end
                end
                ST_FILL, ST_DATA, ST_CRC: begin
                    if (w_push) begin
                        if (w_eob) begin
                            r_bit_cnt <= '0;
                            if (w_last_blk) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_blk_idx <= 1'b1;
                                r_k_big   <= r_blk1_big;
                                r_state   <= ST_DATA;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if ((r_state == ST_FILL) && (r_bit_cnt == r_filler - 1'b1))
                                r_state <= ST_DATA;
                            if ((r_state == ST_DATA) && r_crc_on && w_data_last)
                                r_state <= ST_CRC;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cb_seg_out_reg u_out_reg (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .i_push    (w_push),
        .i_bit     ((r_state == ST_DATA) && in_bit),
        .i_type    (w_type),
        .i_sob     (r_bit_cnt == '0),
        .i_eob     (w_eob),
        .i_blk_idx (r_blk_idx),
        .i_k_big   (r_k_big),
        .i_last    (w_eob && w_last_blk),
        .i_ready   (out_ready),
        .o_can_adv (w_can_adv),
        .o_valid   (out_valid),
        .o_bit     (out_bit),
        .o_type    (w_out_type),
        .o_sob     (out_sob),
        .o_eob     (out_eob),
        .o_blk_idx (out_blk_idx),
        .o_k_big   (out_k_big),
        .o_last    (w_out_last)
    );

endmodule

// File: doc/cb_seg_sequencer.md
Name: cb_seg_sequencer

Overview:
- Consumes one segmentation descriptor {C_plus, C_minus, filler} per transport block from the 20-bit descriptor FIFO, plus the serial transport-block bit stream.
- Emits the segmented code-block bit stream: filler bits, then data bits, then a 24-bit CRC slot per block when C>1.
- Each output bit is tagged with block index, block size and slot type.
- Sits between the size-calculation FIFO and the per-block CRC24B/turbo-encoder input.

Parameters:
- K_BIG, 6144, bit size of a C_plus block.
- K_SMALL, 1056, bit size of a C_minus block.
- CRC_LEN, 24, per-block CRC slot length, used only when C_plus + C_minus = 2.

Ports:
- clk  in  1  clock.
- aclr_n  in  1  asynchronous active-low reset.
- desc_empty  in  1  descriptor FIFO empty.
- desc_rd  out  1  descriptor FIFO read request; q valid the cycle after.
- desc_q  in  20  descriptor: [19:18] C_plus, [17:16] C_minus, [15:0] filler.
- in_valid  in  1  TB data bit valid.
- in_bit  in  1  TB data bit.
- in_ready  out  1  TB data bit accepted when in_valid & in_ready.
- out_valid  out  1  output bit valid.
- out_ready  in  1  downstream accepts.
- out_bit  out  1  output bit (0 for filler and CRC slots).
- out_type  out  2  00 data, 01 filler, 10 CRC slot.
- out_sob  out  1  first bit of a code block.
- out_eob  out  1  last bit of a code block.
- out_blk_idx  out  1  block index within the TB (0/1).
- out_k_big  out  1  1 = current block is K_BIG.
- tb_done  out  1  one-cycle pulse when the last bit of a TB is accepted.
- desc_err  out  1  one-cycle pulse on descriptor rejection.

Behaviour:
- Reset (aclr_n low, async): state IDLE; all outputs 0; counters cleared. Reset mid-block abandons the TB; no resume.
- Output stage: single register. It advances when !out_valid | out_ready. out_valid holds until accepted, and payload stays stable while out_valid & !out_ready.
- FSM states: IDLE, LOAD, FILL, DATA, CRC.
- IDLE: if !desc_empty, assert desc_rd for one cycle and go to LOAD.
- LOAD: latch desc_q and compute:
  - C = C_plus + C_minus.
  - Block order: all C_minus (K_SMALL) blocks first, then C_plus blocks.
  - crc_on = (C == 2).
  - cap0 = K0 - (crc_on ? CRC_LEN : 0), where K0 is the size of block 0.
- LOAD rejection: reject if C == 0, C > 2, or filler >= cap0. On reject, pulse desc_err and return to IDLE with no output. Otherwise blk_idx=0, bit_cnt=0, and go to FILL if filler != 0, else DATA.
- FILL (block 0 only): emit filler bits with out_type=01, bit 0; no input consumed. After filler bits go to DATA.
- DATA: in_ready = output stage can advance. Each accepted input bit emits out_type=00. DATA length per block is K - filler(block 0 only) - (crc_on ? CRC_LEN : 0).
- in_valid low in DATA: a bubble; no output bit and no count.
- After DATA: go to CRC if crc_on, else end of block.
- CRC: emit CRC_LEN slot bits, type 10, value 0; downstream overwrites them. No input consumed.
- Block counting: bit_cnt is 13 bits and counts emitted bits 0..K-1.
  - out_sob on bit_cnt==0; out_eob on bit_cnt==K-1.
  - At eob, if blk_idx < C-1: increment blk_idx, clear bit_cnt, go to DATA (block 1 has no filler).
  - Else pulse tb_done when that bit is accepted and go to IDLE.
- Back-to-back TBs: the next desc_rd may issue in the cycle after tb_done. Descriptor FIFO read never overlaps an active TB.
- in_ready is 0 outside DATA.
- tb_done and desc_err are never asserted in the same cycle.
- Arithmetic: filler is compared as unsigned 16-bit. A wrapped (huge) filler from an oversize TB is therefore rejected by the cap0 check.

Decomposition:
- Shared package cb_seg_pkg: K_BIG, K_SMALL, CRC_LEN localparams; slot_type_t enum (DATA, FILL, CRC); seg_state_t enum; desc_t packed struct {c_plus, c_minus, filler}.
- One natural sub-module, cb_seg_out_reg: the ready/valid output register stage holding bit, type, sob, eob, blk_idx and k_big.

Test Plan:
- Desc {C+=0, C-=1, filler=56}, 1000 input bits.
  - Expect 1056 bits: 56 type-01, then 1000 type-00 in order.
  - sob on bit 0, eob on bit 1055, k_big=0, no CRC slots, tb_done once.
- Desc {1, 0, 0}, 6144 input bits.
  - Expect 6144 data bits, k_big=1, no filler, no CRC slot.
- Desc {1, 1, 152}, 7000 input bits.
  - Block 0 (k_big=0): 152 filler + 880 data + 24 CRC.
  - Block 1 (k_big=1): 6120 data + 24 CRC.
  - Total 7200 bits, tb_done once.
- Desc {2, 0, 0}, 12240 input bits.
  - Two blocks of 6120 data + 24 CRC each; blk_idx 0 then 1.
- Reject cases, each with no output and in_ready held 0:
  - desc 20'h00000 → desc_err.
  - desc {0, 1, 1056} → desc_err.
  - desc {2, 0, 16'hFFF0} → desc_err.
- Robustness:
  - Random out_ready and in_valid gaps on the {1, 1, 152} case: bit sequence identical to the stall-free run, payload stable under stall.
  - aclr_n pulsed low mid-block 1: outputs 0 immediately; a fresh descriptor then processes correctly.
